// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a first-word-fall-through FIFO with sticky error flags
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clear_err,
  output logic [7:0]                    data_out,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rxs;
  logic [TW-1:0] tick, tick_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sr, sr_n;
  logic push, pop, full, set_ovr, set_fe;
  logic [7:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign rx_valid = fifo_count != '0;
  assign full     = fifo_count == CW'(FIFO_DEPTH);
  assign pop      = rd_en && rx_valid;
  assign data_out = mem[rd_ptr];
  // two-flop synchroniser, idle-high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rxs} <= 2'b11;
    else {rx_m, rxs} <= {rx, rx_m};
  // receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tick  <= '0;
      bitn  <= '0;
      sr    <= '0;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitn  <= bitn_n;
      sr    <= sr_n;
    end
  // next-state decode; STOP samples mid-bit so IDLE re-arms half a bit early
  always_comb begin
    state_n = state;
    tick_n  = tick + TW'(1);
    bitn_n  = bitn;
    sr_n    = sr;
    push    = 1'b0;
    set_ovr = 1'b0;
    set_fe  = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        if (!rxs) state_n = START;
      end
      START:
        if (tick == HALF) begin
          tick_n  = '0;
          bitn_n  = '0;
          state_n = rxs ? IDLE : DATA;
        end
      DATA:
        if (tick == LAST) begin
          tick_n = '0;
          sr_n   = {rxs, sr[7:1]};
          if (bitn == 3'd7) state_n = STOP;
          else bitn_n = bitn + 3'd1;
        end
      default:
        if (tick == LAST) begin
          tick_n  = '0;
          state_n = IDLE;
          push    = rxs && (!full || pop);
          set_ovr = rxs && full && !pop;
          set_fe  = !rxs;
        end
    endcase
  end
  // circular buffer; a push into a full FIFO is accepted only alongside a pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= sr;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  // sticky error flags; a set event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= set_ovr || (overrun && !clear_err);
      frame_err <= set_fe || (frame_err && !clear_err);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo at 16 clocks/bit, depth 4
module tb_uart_rx_fifo;
  logic clk = 0;
  logic rst_n = 0;
  logic rx = 1;
  logic rd_en = 0;
  logic clear_err = 0;
  logic [7:0] data_out;
  logic rx_valid;
  logic [2:0] fifo_count;
  logic overrun;
  logic frame_err;
  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en), .clear_err(clear_err),
    .data_out(data_out), .rx_valid(rx_valid), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1;
      rd_en = 0;
      clear_err = 0;
    end
  endtask

  // Drives one 8N1 frame, one bit per 16 negedges; the stop sample lands at the
  // posedge following negedge 154, so pop_at/clr_at = 154 coincide with it.
  task automatic send(input logic [7:0] b, input logic stop, input int len,
                      input int pop_at, input int clr_at);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rx = (c < 16) ? 1'b0 : (c < 144) ? b[(c - 16) / 16] : stop;
      rd_en = (c == pop_at);
      clear_err = (c == clr_at);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, {31'd0, rx_valid}, 32'd1);
    chk(tag, {24'd0, data_out}, {24'd0, exp});
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  initial begin
    #1;
    chk("reset_valid", {31'd0, rx_valid}, 0);
    chk("reset_count", {29'd0, fifo_count}, 0);
    chk("reset_ovr", {31'd0, overrun}, 0);
    chk("reset_fe", {31'd0, frame_err}, 0);
    chk("reset_data", {24'd0, data_out}, 0);
    @(negedge clk);
    rst_n = 1;
    idle(5);

    send(8'hA5, 1, 160, -1, -1);
    chk("a5_count", {29'd0, fifo_count}, 1);
    chk("a5_ovr", {31'd0, overrun}, 0);
    chk("a5_fe", {31'd0, frame_err}, 0);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_empty_valid", {31'd0, rx_valid}, 0);
    chk("a5_empty_count", {29'd0, fifo_count}, 0);
    @(negedge clk);
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    chk("underflow_count", {29'd0, fifo_count}, 0);

    for (int i = 1; i <= 5; i++) send(8'(i), 1, 160, -1, -1);
    chk("full_count", {29'd0, fifo_count}, 4);
    chk("full_ovr", {31'd0, overrun}, 1);
    chk("full_fe", {31'd0, frame_err}, 0);
    pop_chk("ovr_pop1", 8'h01);
    chk("pop_dec_count", {29'd0, fifo_count}, 3);
    pop_chk("ovr_pop2", 8'h02);
    pop_chk("ovr_pop3", 8'h03);
    pop_chk("ovr_pop4", 8'h04);
    chk("ovr_drained", {31'd0, rx_valid}, 0);
    chk("ovr_still_set", {31'd0, overrun}, 1);
    @(negedge clk);
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;
    chk("ovr_cleared", {31'd0, overrun}, 0);

    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1, 160, -1, -1);
    send(8'h55, 1, 160, 154, -1);
    @(negedge clk);
    rd_en = 0;
    chk("pushpop_count", {29'd0, fifo_count}, 4);
    chk("pushpop_ovr", {31'd0, overrun}, 0);
    pop_chk("pushpop_pop1", 8'h12);
    pop_chk("pushpop_pop2", 8'h13);
    pop_chk("pushpop_pop3", 8'h14);
    pop_chk("pushpop_tail", 8'h55);
    chk("pushpop_empty", {31'd0, rx_valid}, 0);

    send(8'h3C, 0, 160, -1, -1);
    idle(20);
    chk("fe_set", {31'd0, frame_err}, 1);
    chk("fe_count", {29'd0, fifo_count}, 0);
    chk("fe_ovr", {31'd0, overrun}, 0);
    @(negedge clk);
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;
    chk("fe_cleared", {31'd0, frame_err}, 0);
    send(8'h3C, 0, 160, -1, 154);
    @(negedge clk);
    clear_err = 0;
    chk("fe_set_wins", {31'd0, frame_err}, 1);
    idle(20);
    @(negedge clk);
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 0;
    end
    idle(40);
    chk("glitch_count", {29'd0, fifo_count}, 0);
    chk("glitch_valid", {31'd0, rx_valid}, 0);
    chk("glitch_ovr", {31'd0, overrun}, 0);
    chk("glitch_fe", {31'd0, frame_err}, 0);
    send(8'h96, 1, 160, -1, -1);
    chk("post_glitch_count", {29'd0, fifo_count}, 1);
    pop_chk("post_glitch_data", 8'h96);

    send(8'h00, 0, 160, -1, -1);
    idle(20);
    send(8'h5A, 1, 160, -1, -1);
    send(8'hC3, 1, 160, -1, -1);
    chk("pre_rst_count", {29'd0, fifo_count}, 2);
    chk("pre_rst_fe", {31'd0, frame_err}, 1);
    send(8'hFF, 1, 80, -1, -1);
    @(negedge clk);
    rst_n = 0;
    rx = 1;
    #1;
    chk("rst_valid", {31'd0, rx_valid}, 0);
    chk("rst_count", {29'd0, fifo_count}, 0);
    chk("rst_fe", {31'd0, frame_err}, 0);
    chk("rst_ovr", {31'd0, overrun}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(5);
    send(8'h7E, 1, 160, -1, -1);
    chk("after_rst_count", {29'd0, fifo_count}, 1);
    chk("after_rst_fe", {31'd0, frame_err}, 0);
    pop_chk("after_rst_data", 8'h7E);
    chk("after_rst_empty", {31'd0, rx_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the d16 MMIO UART. Sits directly upstream of the core's `rx` input path: it deserialises the asynchronous 8N1 line, buffers received bytes in a small first-word-fall-through FIFO, and presents them to the MMIO read logic with a pop handshake and sticky error flags.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit period; integer ≥ 4.
- `FIFO_DEPTH`, default 4: FIFO entries; power of two ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `rd_en`  in  1  pop request from MMIO read logic.
- `clear_err`  in  1  clears both sticky error flags.
- `data_out`  out  8  FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.
- `frame_err`  out  1  sticky: the stop bit sampled low.

## Operation
- Input sync: 2-flop synchroniser on `rx`, both flops reset to 1. All receiver logic uses the synchronised `rxs`.
- Bit counter `tick`: width $clog2(CLKS_PER_BIT). Bit index `bitn`: 3 bits. Shift register: 8 bits, LSB first.
- State machine, reset state IDLE:
  - IDLE: on `rxs`=0, load `tick`=0 and go to START.
  - START: at `tick`=CLKS_PER_BIT/2−1 (integer division), sample `rxs`. If 0, go to DATA with `tick`=0 and `bitn`=0. If 1 (glitch/false start), return to IDLE with no flags set.
  - DATA: at `tick`=CLKS_PER_BIT−1, shift `rxs` into bit 7 of the shift register with a right shift, and set `tick`=0. After bit 7 (`bitn`=7), go to STOP; otherwise increment `bitn`.
  - STOP: at `tick`=CLKS_PER_BIT−1, sample `rxs`, then return to IDLE.
    - If the sample is 1 and the push is accepted: push the byte.
    - If the sample is 1 and the FIFO is full with no pop this cycle: drop the byte and set `overrun`.
    - If the sample is 0: discard the byte and set `frame_err`.
- IDLE re-arms on a low `rxs`. After a framing error with the line held low (break), START runs and detects 0, so a break produces repeated frames of 0x00 with `frame_err`. This behaviour is required.
- FIFO: circular buffer with read and write pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
  - `data_out` = mem[rd_ptr], combinational, first-word-fall-through.
  - Pop when `rd_en` && `rx_valid`. `rd_en` while empty is ignored, with no underflow.
  - Push accepted when count<FIFO_DEPTH, or when count=FIFO_DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Sticky flags:
  - `clear_err` clears both flags.
  - If a set event and `clear_err` occur in the same cycle, set wins.

## Timing
- Reset values:
  - `rx_valid`=0, `fifo_count`=0, `overrun`=0, `frame_err`=0.
  - `data_out`=0x00; FIFO memory is reset to 0.
  - State machine in IDLE; pointers and counters at 0; sync flops at 1.
- Async reset mid-frame: the partial byte is lost, the FIFO is emptied, and receive restarts from IDLE once `rst_n` deasserts.
- Latency:
  - `rx` falling edge to IDLE→START transition: 2–3 cycles (synchroniser).
  - START sample is taken CLKS_PER_BIT/2 cycles after entering START.
  - Data bit n is sampled (n+1)·CLKS_PER_BIT cycles after the START sample.
  - Stop bit is sampled 9·CLKS_PER_BIT cycles after the START sample.
  - `rx_valid`/`fifo_count` update on the clock edge after the stop-sample cycle, i.e. 1-cycle push latency.
- Pop: `data_out` shows the next entry, and `fifo_count` decrements, on the edge after `rd_en` is sampled high.
- Back-to-back frames: a start bit beginning immediately after the stop bit is received without loss, because STOP samples mid-bit and IDLE is re-entered half a bit early.

## Test plan
- CLKS_PER_BIT=16: send 0xA5 as 8N1. Expect `rx_valid`=1, `data_out`=0xA5, `fifo_count`=1, no flags. Pulse `rd_en` for 1 cycle; expect `rx_valid`=0 and `fifo_count`=0.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with no reads (FIFO_DEPTH=4). Expect `fifo_count`=4 and `overrun`=1. Popping yields 0x01..0x04 in order, and 0x05 is absent.
- FIFO full; hold `rd_en`=1 in the exact cycle the 5th byte (0x55) pushes. Expect `fifo_count` stays 4, no `overrun`, and 0x55 at the tail.
- Send 0x3C with a stop bit of 0. Expect `frame_err`=1 and `fifo_count`=0. Pulse `clear_err`; expect `frame_err`=0. Assert `clear_err` in the same cycle as a new framing error; expect `frame_err`=1.
- Drive a 4-cycle low glitch on `rx`. Expect return to IDLE, with no push and no flags.
- Assert `rst_n`=0 mid-byte with 2 entries queued. Immediately expect `rx_valid`=0, `fifo_count`=0, flags 0. After release, 0x7E is received correctly.
